// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte capture into a first-word fall-through FIFO
// A two-state handshake takes each rx_ready level exactly once and pushes the byte into the FIFO.
module uart_rx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     raw_clk,
   input  logic                     reset_n,
   input  logic [7:0]               rx_data,
   input  logic                     rx_ready,
   output logic                     rx_ready_clear,
   input  logic                     pop,
   output logic [7:0]               data_out,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     overflow_clear
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            clr_q, clr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            empty_q, empty_d;
   logic            full_q, full_d;
   logic            ovf_q, ovf_d;
   logic            wr_en, rd_en, drop;
   logic [7:0]      mem_q [DEPTH];

   // Capture happens only on the IDLE->ACK transition, so a lingering rx_ready is never re-sampled.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      wr_en   = 1'b0;
      drop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_ready) begin
               state_d = ACK;
               clr_d   = 1'b1;
               wr_en   = !full_q;
               drop    = full_q;
            end
         end
         ACK: begin
            if (rx_ready) begin
               clr_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_en    = pop && !empty_q;
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
      // A drop in the same cycle as a clear must leave the flag set.
      ovf_d   = drop ? 1'b1 : (overflow_clear ? 1'b0 : ovf_q);
   end

   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         clr_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         clr_q    <= clr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge raw_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

   assign rx_ready_clear = clr_q;
   assign data_out       = empty_q ? 8'h00 : mem_q[rd_ptr_q];
   assign empty          = empty_q;
   assign full           = full_q;
   assign count          = count_q;
   assign overflow       = ovf_q;

endmodule
